// File: rtl/ddr4_mrs_decoder.sv
// rtl/ddr4_mrs_decoder.sv - DDR4 DRAM-side MRS/ZQCL init command decoder and timing checker
//
// Snoops the controller's initialization stream, decodes MR0..MR6 into the
// operating parameters the memory model uses, checks command spacing and
// ordering, and raises init_done once a full MRS set plus ZQCL has completed.
//
// Ports:
//   clock_t    in   main clock, everything on the rising edge
//   reset      in   synchronous active-high reset
//   mrs_rdy    in   MRS command this cycle
//   des_rdy    in   DES (no-op) this cycle
//   zqcl_rdy   in   ZQCL command this cycle
//   mode_reg   in   [18] reserved, [17:15] MR index, [14:0] A14..A0
//   cl         out  CAS read latency  (9 + {MR0[6:4],MR0[2]})
//   cwl        out  CAS write latency (9 + MR2[5:3])
//   tccd_l     out  4 + MR6[12:10]
//   al         out  additive latency (0, cl-1, cl-2)
//   bl         out  MR0[1:0]
//   dll_en     out  MR1[0]
//   wr_pre     out  MR4[12]
//   rd_pre     out  MR4[11]
//   mr_valid   out  bit n set once MRn accepted since reset
//   init_done  out  initialization complete
//   tmrd_err, tmod_err, seq_err, proto_err  out  single-cycle error pulses

module ddr4_mrs_decoder #(
  parameter int T_MRD = 8,
  parameter int T_MOD = 24,
  parameter int T_ZQ  = 1024
) (
  input  logic        clock_t,
  input  logic        reset,
  input  logic        mrs_rdy,
  input  logic        des_rdy,
  input  logic        zqcl_rdy,
  input  logic [18:0] mode_reg,
  output logic [4:0]  cl,
  output logic [4:0]  cwl,
  output logic [3:0]  tccd_l,
  output logic [4:0]  al,
  output logic [1:0]  bl,
  output logic        dll_en,
  output logic        wr_pre,
  output logic        rd_pre,
  output logic [6:0]  mr_valid,
  output logic        init_done,
  output logic        tmrd_err,
  output logic        tmod_err,
  output logic        seq_err,
  output logic        proto_err
);

  localparam int          GAP_W    = 11;
  localparam logic [10:0] GAP_MAX  = 11'h7FF;
  localparam logic [10:0] GAP_MRD  = GAP_W'(T_MRD);
  localparam logic [10:0] GAP_MOD  = GAP_W'(T_MOD);
  localparam int          ZQ_W     = $clog2(T_ZQ);
  localparam logic [ZQ_W-1:0] ZQ_LAST = ZQ_W'(T_ZQ - 1);

  typedef enum logic [1:0] {
    ST_CONFIG  = 2'd0,
    ST_ZQ_WAIT = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Raw stored codes; the visible latencies are derived from these.
  logic [3:0] cl_code;
  logic [2:0] cwl_code;
  logic [2:0] tccd_code;
  logic [1:0] al_code;

  // Clocks since the last accepted MRS. Loaded with 1 on acceptance so that
  // at the edge sampling the next command it holds the exact edge-to-edge
  // spacing. Saturated means "no MRS since reset".
  logic [GAP_W-1:0] gap;
  logic [ZQ_W-1:0]  zq_cnt;

  logic       multi_cmd;
  logic       mrs_cmd;
  logic       zqcl_cmd;
  logic [2:0] mr_idx;
  logic       mr_bad;

  logic mrs_accept;
  logic zq_start;
  logic init_set;
  logic tmrd_nxt;
  logic tmod_nxt;
  logic seq_nxt;
  logic proto_nxt;

  // Address bits no mode register field here depends on.
  logic unused_bits;
  assign unused_bits = ^{mode_reg[14:13], mode_reg[9:7]};

  // Any two command strobes together is a protocol violation; the cycle is
  // then treated as carrying no command at all.
  assign multi_cmd = (mrs_rdy & des_rdy) | (mrs_rdy & zqcl_rdy) | (des_rdy & zqcl_rdy);
  assign mrs_cmd   = mrs_rdy  & ~multi_cmd;
  assign zqcl_cmd  = zqcl_rdy & ~multi_cmd;
  assign mr_idx    = mode_reg[17:15];
  assign mr_bad    = mode_reg[18] | (mr_idx == 3'd7);

  always_ff @(posedge clock_t) begin
    if (reset) begin
      state <= ST_CONFIG;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mrs_accept = 1'b0;
    zq_start   = 1'b0;
    init_set   = 1'b0;
    tmrd_nxt   = 1'b0;
    tmod_nxt   = 1'b0;
    seq_nxt    = 1'b0;
    proto_nxt  = multi_cmd;

    case (state)
      ST_CONFIG: begin
        if (mrs_cmd) begin
          if (mr_bad) begin
            seq_nxt = 1'b1;
          end else begin
            mrs_accept = 1'b1;
          end
        end else if (zqcl_cmd) begin
          if (mr_valid != 7'h7F) begin
            seq_nxt = 1'b1;
          end else begin
            tmod_nxt  = (gap < GAP_MOD);
            zq_start  = 1'b1;
            state_nxt = ST_ZQ_WAIT;
          end
        end
      end

      ST_ZQ_WAIT: begin
        // Commands are rejected but calibration time keeps running.
        if (mrs_cmd || zqcl_cmd) begin
          seq_nxt = 1'b1;
        end
        if (zq_cnt == ZQ_LAST) begin
          init_set  = 1'b1;
          state_nxt = ST_READY;
        end
      end

      ST_READY: begin
        if (mrs_cmd) begin
          if (mr_bad) begin
            seq_nxt = 1'b1;
          end else begin
            mrs_accept = 1'b1;
          end
        end else if (zqcl_cmd) begin
          // Periodic calibration: only the spacing rule is enforced.
          tmod_nxt = (gap < GAP_MOD);
        end
      end

      default: begin
        state_nxt = ST_CONFIG;
      end
    endcase

    if (mrs_accept) begin
      tmrd_nxt = (gap < GAP_MRD);
      // Reserved AL encoding is stored (al then reads 0) but flagged.
      if ((mr_idx == 3'd1) && (mode_reg[4:3] == 2'b11)) begin
        seq_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      gap       <= GAP_MAX;
      zq_cnt    <= '0;
      cl_code   <= '0;
      cwl_code  <= '0;
      tccd_code <= '0;
      al_code   <= '0;
      bl        <= '0;
      dll_en    <= 1'b0;
      wr_pre    <= 1'b0;
      rd_pre    <= 1'b0;
      mr_valid  <= '0;
      init_done <= 1'b0;
      tmrd_err  <= 1'b0;
      tmod_err  <= 1'b0;
      seq_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (mrs_accept) begin
        gap              <= 11'd1;
        mr_valid[mr_idx] <= 1'b1;
        case (mr_idx)
          3'd0: begin
            cl_code <= {mode_reg[6:4], mode_reg[2]};
            bl      <= mode_reg[1:0];
          end
          3'd1: begin
            dll_en  <= mode_reg[0];
            al_code <= mode_reg[4:3];
          end
          3'd2: begin
            cwl_code <= mode_reg[5:3];
          end
          3'd4: begin
            wr_pre <= mode_reg[12];
            rd_pre <= mode_reg[11];
          end
          3'd6: begin
            tccd_code <= mode_reg[12:10];
          end
          default: begin
          end
        endcase
      end else if (gap != GAP_MAX) begin
        gap <= gap + 11'd1;
      end

      if (zq_start) begin
        zq_cnt <= '0;
      end else if (state == ST_ZQ_WAIT) begin
        zq_cnt <= zq_cnt + 1'b1;
      end

      if (init_set) begin
        init_done <= 1'b1;
      end

      tmrd_err  <= tmrd_nxt;
      tmod_err  <= tmod_nxt;
      seq_err   <= seq_nxt;
      proto_err <= proto_nxt;
    end
  end

  assign cl     = 5'd9 + {1'b0, cl_code};
  assign cwl    = 5'd9 + {2'b00, cwl_code};
  assign tccd_l = 4'd4 + {1'b0, tccd_code};

  always_comb begin
    al = 5'd0;
    case (al_code)
      2'b01:   al = cl - 5'd1;
      2'b10:   al = cl - 5'd2;
      default: al = 5'd0;
    endcase
  end

endmodule

// File: tb/tb_ddr4_mrs_decoder.sv
// tb/tb_ddr4_mrs_decoder.sv - scoreboard bench for ddr4_mrs_decoder

module tb_ddr4_mrs_decoder;

  localparam int T_MRD = 8;
  localparam int T_MOD = 24;
  localparam int T_ZQ  = 1024;

  logic        clock_t = 1'b0;
  logic        reset;
  logic        mrs_rdy;
  logic        des_rdy;
  logic        zqcl_rdy;
  logic [18:0] mode_reg;
  logic [4:0]  cl;
  logic [4:0]  cwl;
  logic [3:0]  tccd_l;
  logic [4:0]  al;
  logic [1:0]  bl;
  logic        dll_en;
  logic        wr_pre;
  logic        rd_pre;
  logic [6:0]  mr_valid;
  logic        init_done;
  logic        tmrd_err;
  logic        tmod_err;
  logic        seq_err;
  logic        proto_err;

  always #5 clock_t = ~clock_t;

  ddr4_mrs_decoder #(.T_MRD(T_MRD), .T_MOD(T_MOD), .T_ZQ(T_ZQ)) dut (
    .clock_t   (clock_t),
    .reset     (reset),
    .mrs_rdy   (mrs_rdy),
    .des_rdy   (des_rdy),
    .zqcl_rdy  (zqcl_rdy),
    .mode_reg  (mode_reg),
    .cl        (cl),
    .cwl       (cwl),
    .tccd_l    (tccd_l),
    .al        (al),
    .bl        (bl),
    .dll_en    (dll_en),
    .wr_pre    (wr_pre),
    .rd_pre    (rd_pre),
    .mr_valid  (mr_valid),
    .init_done (init_done),
    .tmrd_err  (tmrd_err),
    .tmod_err  (tmod_err),
    .seq_err   (seq_err),
    .proto_err (proto_err)
  );

  typedef struct {
    int t;
    int cl, cwl, tccd, al, bl, dll, wr, rd, mrv, init, err;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // Reference model: whole mode-register images plus event timestamps.
  logic [14:0] m_mr [7];
  logic [6:0]  m_mrv;
  int          m_t = 0;
  int          m_last;
  int          m_zq_t0;
  bit          m_has_last;
  bit          m_zq_active;
  bit          m_done;

  function automatic exp_t expected(input int err);
    exp_t e;
    int alc;
    e.t    = m_t;
    e.cl   = 9 + 8 * int'(m_mr[0][6]) + 4 * int'(m_mr[0][5]) + 2 * int'(m_mr[0][4]) + int'(m_mr[0][2]);
    e.cwl  = 9 + ((int'(m_mr[2]) >> 3) & 7);
    e.tccd = 4 + ((int'(m_mr[6]) >> 10) & 7);
    alc    = (int'(m_mr[1]) >> 3) & 3;
    e.al   = (alc == 1) ? e.cl - 1 : (alc == 2) ? e.cl - 2 : 0;
    e.bl   = int'(m_mr[0]) & 3;
    e.dll  = int'(m_mr[1][0]);
    e.wr   = int'(m_mr[4][12]);
    e.rd   = int'(m_mr[4][11]);
    e.mrv  = int'(m_mrv);
    e.init = int'(m_done);
    e.err  = err;
    return e;
  endfunction

  task automatic model_step(input logic r, input logic m, input logic d, input logic z,
                            input logic [18:0] mode);
    int tmrd, tmod, seq, proto, gap, ph, idx;
    tmrd = 0; tmod = 0; seq = 0; proto = 0;
    m_t++;
    if (r) begin
      for (int i = 0; i < 7; i++) m_mr[i] = '0;
      m_mrv = '0;
      m_has_last = 0;
      m_zq_active = 0;
      m_done = 0;
    end else begin
      gap = !m_has_last ? 2047 : ((m_t - m_last > 2047) ? 2047 : m_t - m_last);
      ph  = m_done ? 2 : (m_zq_active ? 1 : 0);
      idx = int'(mode[17:15]);
      if (int'(m) + int'(d) + int'(z) > 1) begin
        proto = 1;
      end else if (m) begin
        if (ph == 1 || mode[18] || idx == 7) begin
          seq = 1;
        end else begin
          m_mr[idx]  = mode[14:0];
          m_mrv[idx] = 1'b1;
          tmrd = (gap < T_MRD) ? 1 : 0;
          m_last = m_t;
          m_has_last = 1;
          if (idx == 1 && mode[4:3] == 2'b11) seq = 1;
        end
      end else if (z) begin
        if (ph == 1) seq = 1;
        else if (ph == 2) tmod = (gap < T_MOD) ? 1 : 0;
        else if (m_mrv != 7'h7F) seq = 1;
        else begin
          tmod = (gap < T_MOD) ? 1 : 0;
          m_zq_active = 1;
          m_zq_t0 = m_t;
        end
      end
      if (m_zq_active && !m_done && (m_t - m_zq_t0 == T_ZQ)) m_done = 1;
    end
    exp_q.push_back(expected(tmrd * 8 + tmod * 4 + seq * 2 + proto));
  endtask

  // Monitor: every cycle the DUT presents a new output snapshot.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_t);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("cl c%0d", e.t),        int'(cl),        e.cl);
        chk($sformatf("cwl c%0d", e.t),       int'(cwl),       e.cwl);
        chk($sformatf("tccd_l c%0d", e.t),    int'(tccd_l),    e.tccd);
        chk($sformatf("al c%0d", e.t),        int'(al),        e.al);
        chk($sformatf("bl c%0d", e.t),        int'(bl),        e.bl);
        chk($sformatf("dll/wr/rd c%0d", e.t), int'({dll_en, wr_pre, rd_pre}), e.dll * 4 + e.wr * 2 + e.rd);
        chk($sformatf("mr_valid c%0d", e.t),  int'(mr_valid),  e.mrv);
        chk($sformatf("init_done c%0d", e.t), int'(init_done), e.init);
        chk($sformatf("errs c%0d", e.t),      int'({tmrd_err, tmod_err, seq_err, proto_err}), e.err);
      end
    end
  end

  task automatic step(input logic r, input logic m, input logic d, input logic z,
                      input logic [18:0] mode);
    reset = r; mrs_rdy = m; des_rdy = d; zqcl_rdy = z; mode_reg = mode;
    @(posedge clock_t);
    model_step(r, m, d, z, mode);
    #1;
    reset = 1'b0; mrs_rdy = 1'b0; des_rdy = 1'b0; zqcl_rdy = 1'b0; mode_reg = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 19'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 19'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 19'd0);
  endtask

  task automatic mrs(input int idx, input logic [14:0] payload);
    logic [2:0] i3;
    i3 = 3'(idx);
    step(1'b0, 1'b1, 1'b0, 1'b0, {1'b0, i3, payload});
  endtask

  task automatic zqcl();
    step(1'b0, 1'b0, 1'b0, 1'b1, 19'd0);
  endtask

  // Nominal MR programming order with nominal payloads, spaced tMRD+1.
  task automatic nominal_cfg(input bit skip_mr0);
    int order[7];
    logic [14:0] pay[7];
    order = '{3, 6, 5, 4, 2, 1, 0};
    pay   = '{15'h0020, 15'h0001, 15'h0008, 15'h0000, 15'h1800, 15'h0000, 15'h0000};
    for (int k = 0; k < 7; k++) begin
      if (!(skip_mr0 && order[k] == 0)) begin
        mrs(order[k], pay[order[k]]);
        idle(T_MRD);
      end
    end
  endtask

  task automatic random_episode(input int n);
    int r;
    logic [18:0] mode;
    for (int c = 0; c < n; c++) begin
      r = $urandom_range(0, 999);
      mode = {($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), 15'($urandom)};
      if (r < 650)      step(1'b0, 1'b0, 1'b0, 1'b0, mode);
      else if (r < 750) step(1'b0, 1'b0, 1'b1, 1'b0, mode);
      else if (r < 920) step(1'b0, 1'b1, 1'b0, 1'b0, mode);
      else if (r < 970) step(1'b0, 1'b0, 1'b0, 1'b1, mode);
      else if (r < 978) step(1'b0, 1'b1, 1'b1, 1'b0, mode);
      else if (r < 986) step(1'b0, 1'b1, 1'b0, 1'b1, mode);
      else if (r < 994) step(1'b0, 1'b0, 1'b1, 1'b1, mode);
      else if (r < 998) step(1'b0, 1'b1, 1'b1, 1'b1, mode);
      else              step(1'b1, 1'b0, 1'b0, 1'b0, mode);
    end
  endtask

  initial begin
    reset = 1'b1; mrs_rdy = 1'b0; des_rdy = 1'b0; zqcl_rdy = 1'b0; mode_reg = '0;

    // Nominal full initialization.
    do_reset();
    chk("reset cl", int'(cl), 9);
    chk("reset tccd_l", int'(tccd_l), 4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 19'd0);
    nominal_cfg(1'b0);
    idle(16);
    zqcl();
    idle(T_ZQ - 1);
    chk("init_done before tZQ", int'(init_done), 0);
    idle(1);
    chk("init_done at tZQ", int'(init_done), 1);
    chk("nominal cl", int'(cl), 13);
    chk("nominal cwl", int'(cwl), 10);
    chk("nominal mr_valid", int'(mr_valid), 8'h7F);
    chk("nominal pre/dll", int'({wr_pre, rd_pre, dll_en}), 7);

    // tMRD violation still decodes.
    do_reset();
    mrs(3, 15'h0000);
    idle(4);
    mrs(6, 15'h1400);
    chk("tmrd_err pulse", int'(tmrd_err), 1);
    chk("tccd_l after short MR6", int'(tccd_l), 9);
    idle(1);
    chk("tmrd_err single", int'(tmrd_err), 0);

    // ZQCL with MR0 missing, then completion.
    do_reset();
    nominal_cfg(1'b1);
    idle(16);
    zqcl();
    chk("seq_err missing MR0", int'(seq_err), 1);
    idle(T_MRD);
    mrs(0, 15'h0020);
    idle(T_MOD);
    zqcl();
    idle(T_ZQ);
    chk("init_done after MR0 fix", int'(init_done), 1);

    // Additive latency reprogramming in READY.
    idle(T_MRD);
    mrs(1, 15'h0009);
    chk("al cl-1", int'(al), 12);
    idle(T_MRD);
    mrs(1, 15'h0011);
    chk("al cl-2", int'(al), 11);
    idle(T_MRD);
    mrs(1, 15'h0019);
    chk("al reserved", int'(al), 0);
    chk("seq_err reserved al", int'(seq_err), 1);

    // Protocol collision and short tMOD.
    idle(T_MRD);
    step(1'b0, 1'b1, 1'b1, 1'b0, {1'b0, 3'd2, 15'h0038});
    chk("proto_err", int'(proto_err), 1);
    chk("cwl unchanged", int'(cwl), 10);
    idle(T_MRD);
    mrs(5, 15'h0000);
    idle(9);
    zqcl();
    chk("tmod_err", int'(tmod_err), 1);
    chk("init_done kept", int'(init_done), 1);

    // Reset in the middle of ZQ_WAIT, then full re-sequence.
    do_reset();
    nominal_cfg(1'b0);
    idle(16);
    zqcl();
    idle(300);
    step(1'b1, 1'b0, 1'b0, 1'b0, 19'd0);
    chk("mid-zq reset mr_valid", int'(mr_valid), 0);
    chk("mid-zq reset init_done", int'(init_done), 0);
    chk("mid-zq reset cwl", int'(cwl), 9);
    idle(T_ZQ);
    chk("no init after partial", int'(init_done), 0);
    nominal_cfg(1'b0);
    idle(16);
    zqcl();
    idle(T_ZQ);
    chk("init_done resequence", int'(init_done), 1);

    // Randomized traffic against the model.
    for (int ep = 0; ep < 3; ep++) begin
      do_reset();
      random_episode(1500);
    end

    idle(2);
    @(negedge clock_t);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr4_mrs_decoder.md
Name: ddr4_mrs_decoder

Overview:
- DRAM-side receiver for the controller's initialization command stream: mode-register-set (MRS), deselect (DES) and long ZQ calibration (ZQCL).
- Decodes MR0–MR6 payloads into the operating parameters the memory model uses: CL, CWL, tCCD_L, AL, burst length and preamble.
- Checks command spacing (tMRD, tMOD, tZQ) and ordering, then declares the device initialized.
- Sits beside the memory model and snoops the controller interface.

Parameters:
- tMRD, 8, minimum clocks between consecutive accepted MRS commands.
- tMOD, 24, minimum clocks from the last MRS to ZQCL.
- tZQ, 1024, clocks from ZQCL acceptance until init_done is asserted.

Ports:
- clock_t  in  1  main clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mrs_rdy  in  1  MRS command valid this cycle.
- des_rdy  in  1  DES (no-op) this cycle.
- zqcl_rdy  in  1  ZQCL command valid this cycle.
- mode_reg  in  19  [18] reserved (0), [17:15] MR index, [14:0] payload A14..A0.
- cl  out  5  CAS read latency = 9 + {MR0[6:4],MR0[2]}.
- cwl  out  5  CAS write latency = 9 + MR2[5:3].
- tccd_l  out  4  = 4 + MR6[12:10].
- al  out  5  additive latency: 0, cl-1 or cl-2.
- bl  out  2  MR0[1:0].
- dll_en  out  1  MR1[0].
- wr_pre, rd_pre  out  1 each  MR4[12], MR4[11].
- mr_valid  out  7  bit n set once MRn has been accepted since reset.
- init_done  out  1  initialization complete.
- tmrd_err, tmod_err, seq_err, proto_err  out  1 each  single-cycle error pulses.

Behaviour:
- Reset (synchronous): all outputs 0, except cl=9, cwl=9 and tccd_l=4. Decoded fields are stored as raw codes. FSM goes to CONFIG; counters clear.
- Sampling and latency: commands are sampled at the rising edge of clock_t. Decoded outputs and mr_valid update at the edge where the MRS is sampled and are visible the following cycle.
- al is combinational from the stored MR1[4:3] code and cl:
  - 00 -> 0
  - 01 -> cl-1
  - 10 -> cl-2
  - 11 -> 0, and seq_err pulses when that MR1 is accepted.
- Protocol error: more than one of mrs_rdy/des_rdy/zqcl_rdy high in a cycle -> proto_err pulse; command ignored; no state change.
- Gap counter: counts clocks since the last accepted MRS, saturating at 2^11-1. It is "infinite" (saturated) after reset.
- MRS acceptance checks:
  - Gap < tMRD -> tmrd_err pulse; the MRS is still decoded and accepted.
  - MR index 7 or mode_reg[18]=1 -> seq_err pulse; not stored; gap counter not reset.
- FSM states:
  - CONFIG: MRS decoded per the rules above. On ZQCL:
    - mr_valid != 7'h7F -> seq_err pulse; ZQCL ignored; stay in CONFIG.
    - otherwise, if gap < tMOD -> tmod_err pulse; proceed anyway.
    - go to ZQ_WAIT with the ZQ counter = 0.
  - ZQ_WAIT: counter increments each cycle. When the counter reaches tZQ-1, init_done is set at the next edge; go to READY. init_done therefore first reads 1 exactly tZQ cycles after the ZQCL sample edge. Any MRS or ZQCL here -> seq_err pulse; command ignored; counter continues.
  - READY: init_done stays 1.
    - MRS is accepted (reprogramming) with the tMRD check.
    - ZQCL is accepted silently with no state change (periodic calibration), tMOD check still applied.
- DES is accepted in any state with no effect.
- Reset asserted in any state, including mid-ZQ_WAIT, returns to the reset values on that edge. init_done never asserts from a partial sequence.

Test Plan:
- Nominal sequence: DES, then MR3, MR6 (cas=0), MR5, MR4 (W/R pre=1), MR2 (wr=1), MR1 (AL=00, DLL=1), MR0 (rd=4, BL=00), each spaced tMRD+1, then ZQCL after tMOD. Required: cl=13, cwl=10, tccd_l=4, al=0, bl=0, wr_pre=rd_pre=dll_en=1, mr_valid=7'h7F, init_done rises exactly 1024 cycles after the ZQCL sample, and no error pulses.
- MR3 then MR6 only 5 cycles apart -> tmrd_err pulses once; MR6 still decoded (tccd_l updated).
- ZQCL issued with MR0 missing -> seq_err pulse; FSM stays in CONFIG. Completing MR0 then issuing ZQCL after tMOD reaches init_done.
- MR1 AL=01 with cl=13 -> al=12; reprogram MR1 AL=10 in READY -> al=11; AL=11 -> al=0 plus seq_err.
- mrs_rdy and des_rdy both high -> proto_err; mr_valid unchanged. ZQCL only 10 cycles after the last MRS -> tmod_err.
- reset pulsed 300 cycles into ZQ_WAIT -> all outputs return to reset values, init_done stays 0, and a full re-sequence succeeds.
